push_requester: RTL and testbench

- Initiator side of the transpush/sequen toggle handshake.
- Turns a raw, bouncy player button into exactly one transpush request per press.
- Holds transpush high until the downstream toggle block acknowledges by flipping sequen, then releases.
- Sits between the board button pin and the game-state toggle block. Reports busy, timeout and accepted-push count to the display logic.

---
 rtl/push_requester.sv | 178 +++++++++++++++++
 tb/tb_push_requester.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/push_requester.sv
// push_requester
//   Initiator side of the transpush/sequen toggle handshake. A bouncy player
//   button is synchronized and debounced; each debounced press raises one
//   transpush request that is held until the responder flips sequen (or a
//   timeout expires). The FSM then waits for the button to be released
//   before it will accept another press, so a long hold yields one request.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   btn_raw      raw push-button level, asynchronous to clk
//   sequen       toggle state returned by the responder, asynchronous
//   transpush    registered request to the responder
//   busy         registered, high whenever the FSM is not idle
//   timeout_err  registered sticky flag: last request was not acknowledged
//   push_count   registered saturating count of acknowledged requests
module push_requester #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 16,
   parameter int COUNT_W         = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_raw,
   input  logic               sequen,
   output logic               transpush,
   output logic               busy,
   output logic               timeout_err,
   output logic [COUNT_W-1:0] push_count
);

   localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Two-flop synchronizers: bit 0 = button, bit 1 = sequen
   // ------------------------------------------------------------------
   logic [1:0] sync_in;
   logic [1:0] sync_out;

   assign sync_in = {sequen, btn_raw};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         logic s1_reg;
         logic s2_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               s1_reg <= 1'b0;
               s2_reg <= 1'b0;
            end else begin
               s1_reg <= sync_in[gi];
               s2_reg <= s1_reg;
            end
         end

         assign sync_out[gi] = s2_reg;
      end
   endgenerate

   logic btn_s;
   logic seq_s;

   assign btn_s = sync_out[0];
   assign seq_s = sync_out[1];

   // ------------------------------------------------------------------
   // Debounce: the debounced level follows btn_s only after btn_s has
   // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
   // ------------------------------------------------------------------
   logic [DB_W-1:0] db_cnt_reg;
   logic            btn_db_reg;
   logic            btn_db_d_reg;
   logic            press;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_cnt_reg   <= '0;
         btn_db_reg   <= 1'b0;
         btn_db_d_reg <= 1'b0;
      end else begin
         btn_db_d_reg <= btn_db_reg;
         if (btn_s == btn_db_reg) begin
            db_cnt_reg <= '0;
         end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_db_reg <= btn_s;
            db_cnt_reg <= '0;
         end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
         end
      end
   end

   // One-cycle pulse on the debounced rising edge
   assign press = btn_db_reg & ~btn_db_d_reg;

   // ------------------------------------------------------------------
   // Request FSM with registered Moore outputs
   // ------------------------------------------------------------------
   state_t             state_reg;
   logic               seq_ref_reg;
   logic [TMO_W-1:0]   tmo_cnt_reg;
   logic               transpush_reg;
   logic               busy_reg;
   logic               timeout_err_reg;
   logic [COUNT_W-1:0] push_count_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         seq_ref_reg     <= 1'b0;
         tmo_cnt_reg     <= '0;
         transpush_reg   <= 1'b0;
         busy_reg        <= 1'b0;
         timeout_err_reg <= 1'b0;
         push_count_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (press) begin
                  // Remember the responder's current toggle state; any
                  // change from it while asserting is the acknowledge.
                  seq_ref_reg   <= seq_s;
                  tmo_cnt_reg   <= '0;
                  state_reg     <= ASSERT;
                  transpush_reg <= 1'b1;
                  busy_reg      <= 1'b1;
               end
            end

            ASSERT: begin
               tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               // Acknowledge is tested first so it wins a same-cycle tie
               if (seq_s != seq_ref_reg) begin
                  if (push_count_reg != {COUNT_W{1'b1}}) begin
                     push_count_reg <= push_count_reg + 1'b1;
                  end
                  timeout_err_reg <= 1'b0;
                  state_reg       <= HOLDOFF;
                  transpush_reg   <= 1'b0;
               end else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  timeout_err_reg <= 1'b1;
                  state_reg       <= HOLDOFF;
                  transpush_reg   <= 1'b0;
               end
            end

            HOLDOFF: begin
               // Wait for release so a long hold cannot re-trigger
               if (!btn_db_reg) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end

            default: begin
               state_reg     <= IDLE;
               transpush_reg <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign transpush   = transpush_reg;
   assign busy        = busy_reg;
   assign timeout_err = timeout_err_reg;
   assign push_count  = push_count_reg;

endmodule

// File: tb/tb_push_requester.sv
module tb_push_requester;

   localparam int D   = 4;
   localparam int T   = 16;
   localparam int CW  = 2;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          btn_raw = 1'b0;
   logic          sequen = 1'b0;
   logic          transpush;
   logic          busy;
   logic          timeout_err;
   logic [CW-1:0] push_count;

   int errors = 0;
   int checks = 0;

   // Reference model state: what the counters should read after each request
   int exp_count = 0;
   bit exp_err   = 1'b0;

   // Scoreboard: expected {count, err} at each request completion
   int sb_count_q[$];
   bit sb_err_q[$];

   push_requester #(
      .DEBOUNCE_CYCLES(D),
      .TIMEOUT_CYCLES (T),
      .COUNT_W        (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw),
      .sequen     (sequen),
      .transpush  (transpush),
      .busy       (busy),
      .timeout_err(timeout_err),
      .push_count (push_count)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: outcome of one request, expressed as the resulting counters
   task automatic model_request(input bit acked);
      if (acked) begin
         exp_count = (exp_count < MAXC) ? exp_count + 1 : MAXC;
         exp_err   = 1'b0;
      end else begin
         exp_err   = 1'b1;
      end
      sb_count_q.push_back(exp_count);
      sb_err_q.push_back(exp_err);
   endtask

   // Monitor: every completed request (transpush falling out of reset) is
   // compared with the oldest scoreboard entry.
   initial begin
      bit prev;
      int c;
      bit e;
      prev = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst) begin
            prev = 1'b0;
         end else begin
            if (prev && !transpush) begin
               if (sb_count_q.size() == 0) begin
                  check("sb_unexpected_request", 1, 0);
               end else begin
                  c = sb_count_q.pop_front();
                  e = sb_err_q.pop_front();
                  check("sb_push_count", int'(push_count), c);
                  check("sb_timeout_err", int'(timeout_err), int'(e));
                  $display("request done: push_count=%0d timeout_err=%0d (model %0d/%0d)",
                           push_count, timeout_err, c, e);
               end
            end
            prev = transpush;
         end
      end
   end

   // One button press. ack_d < 0 means the responder never answers.
   task automatic do_press(input int ack_d, input int hold, input bit glitch);
      int n;
      int held;
      int hi;
      btn_raw = 1'b1;
      n = 0;
      while (!transpush && n < 40) begin
         tick();
         n++;
      end
      // n ticks covered edges 0..n-1
      check("rise_latency", n - 1, D + 2);
      held = n;
      if (ack_d >= 0) begin
         model_request(1'b1);
         repeat (ack_d) begin
            tick();
            held++;
         end
         sequen = ~sequen;
         tick(); held++;
         check("hold_at_sample_edge", int'(transpush), 1);
         tick(); held++;
         check("hold_after_sync1", int'(transpush), 1);
         tick(); held++;
         check("drop_after_ack", int'(transpush), 0);
      end else begin
         model_request(1'b0);
         hi = 0;
         while (transpush && hi < 40) begin
            if (glitch && hi == 5) begin
               // Pulse between edges: never sampled, must not acknowledge
               #2 sequen = ~sequen;
               #2 sequen = ~sequen;
            end
            tick();
            held++;
            hi++;
         end
         check("assert_width", hi, T);
      end
      check("busy_in_holdoff", int'(busy), 1);
      while (held < hold) begin
         if ((held % 7) == 0) sequen = ~sequen;  // ignored outside ASSERT
         tick();
         held++;
         if (transpush) check("no_retrigger_on_hold", int'(transpush), 0);
      end
      btn_raw = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      check("busy_release", int'(busy), 0);
      check("count_after_press", int'(push_count), exp_count);
      check("err_after_press", int'(timeout_err), int'(exp_err));
      $display("press ack_d=%0d hold=%0d -> push_count=%0d timeout_err=%0d",
               ack_d, hold, push_count, timeout_err);
      repeat (3) tick();
   endtask

   // Short button pulses must never raise a request
   task automatic bounce(input int len);
      int seen;
      seen = 0;
      btn_raw = 1'b1;
      repeat (len) begin
         tick();
         if (transpush) seen++;
      end
      btn_raw = 1'b0;
      repeat (2) begin
         tick();
         if (transpush) seen++;
      end
      check("bounce_no_request", seen, 0);
      $display("bounce len=%0d -> transpush cycles=%0d", len, seen);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      int h;

      // Reset held: outputs zero whatever the inputs do
      repeat (10) begin
         btn_raw = 1'($urandom_range(0, 1));
         sequen  = 1'($urandom_range(0, 1));
         tick();
         check("reset_outputs", int'({transpush, busy, timeout_err, push_count}), 0);
      end
      btn_raw = 1'b0;
      sequen  = 1'b0;
      tick();
      rst = 1'b1;
      repeat (8) tick();
      check("post_reset_outputs", int'({transpush, busy, timeout_err, push_count}), 0);

      // Clean press with acknowledge after 5 cycles
      do_press(5, 0, 1'b0);

      // Bounce rejection
      bounce(1);
      bounce(2);
      bounce(3);
      repeat (4) tick();
      check("bounce_count", int'(push_count), exp_count);

      // Timeout with an unsampled glitch, then a recovering acked press
      do_press(-1, 0, 1'b1);
      do_press(3, 0, 1'b0);

      // Long hold with ack: one request only
      do_press(2, 100, 1'b0);

      // Ack on the timeout cycle: acknowledge must win
      do_press(13, 0, 1'b0);

      // Randomized presses
      for (int i = 0; i < 8; i++) begin
         d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 13));
         h = int'($urandom_range(0, 40));
         do_press(d, h, 1'b0);
      end

      // Reset during ASSERT drops everything asynchronously
      btn_raw = 1'b1;
      d = 0;
      while (!transpush && d < 40) begin
         tick();
         d++;
      end
      check("mid_reset_reached_assert", int'(transpush), 1);
      tick();
      #2 rst = 1'b0;
      #1;
      check("mid_reset_outputs", int'({transpush, busy, timeout_err, push_count}), 0);
      btn_raw = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      exp_count = 0;
      exp_err   = 1'b0;
      repeat (8) tick();
      check("after_mid_reset", int'({transpush, busy, timeout_err, push_count}), 0);

      // Saturation: 1, 2, 3, 3, 3
      for (int i = 0; i < 5; i++) begin
         do_press(int'($urandom_range(0, 10)), 0, 1'b0);
         check("saturation_seq", int'(push_count), (i < 3) ? i + 1 : 3);
      end

      repeat (5) tick();
      check("scoreboard_drained", sb_count_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
